// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW      = 12;
  localparam int DEF_DW      = 16;
  localparam int DEF_MEM_LAT = 2;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DP} owner_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter tracking the memory read latency.
// done is high in the last wait cycle, when the count reaches 1 while enabled.
module lat_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done = en && (count == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (IF) and datapath (DP).
// Define MEM_ARB_RR_EN for round-robin on ties; default is fixed DP priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dp_req,
  input  logic          dp_we,
  input  logic [AW-1:0] dp_addr,
  input  logic [DW-1:0] dp_wdata,
  output logic          dp_gnt,
  output logic          dp_rvalid,
  output logic [DW-1:0] dp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t state, state_nxt;
  owner_t owner_q;
  logic   grant_if, grant_dp, issue_rd, rd_done;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
`endif

  // Grants exist only in IDLE and are suppressed while reset is held.
  always_comb begin
    grant_if = 1'b0;
    grant_dp = 1'b0;
    if ((state == IDLE) && !rst) begin
`ifdef MEM_ARB_RR_EN
      if (if_req && dp_req) begin
        if (last_owner == OWN_DP) grant_if = 1'b1;
        else                      grant_dp = 1'b1;
      end else begin
        grant_if = if_req;
        grant_dp = dp_req;
      end
`else
      grant_dp = dp_req;
      grant_if = if_req && !dp_req;
`endif
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_dp) begin
      mem_en    = 1'b1;
      mem_we    = dp_we;
      mem_addr  = dp_addr;
      mem_wdata = dp_wdata;
    end else if (grant_if) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  assign if_gnt   = grant_if;
  assign dp_gnt   = grant_dp;
  assign issue_rd = grant_if || (grant_dp && !dp_we);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_rd) state_nxt = RD_WAIT;
      RD_WAIT: if (rd_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lat_counter #(.CW(CW)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (issue_rd),
    .load_val (CW'(MEM_LAT)),
    .en       (state == RD_WAIT),
    .done     (rd_done)
  );

  // Returned data is captured for the latched owner; rvalid follows one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= OWN_IF;
      if_rvalid <= 1'b0;
      dp_rvalid <= 1'b0;
      if_rdata  <= '0;
      dp_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= rd_done && (owner_q == OWN_IF);
      dp_rvalid <= rd_done && (owner_q == OWN_DP);
      if (issue_rd) owner_q <= grant_dp ? OWN_DP : OWN_IF;
      if (rd_done && (owner_q == OWN_IF)) if_rdata <= mem_rdata;
      if (rd_done && (owner_q == OWN_DP)) dp_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_IF;
    end else if (grant_dp) begin
      last_owner <= OWN_DP;
    end else if (grant_if) begin
      last_owner <= OWN_IF;
    end
  end
`endif

endmodule
